// File: rtl/bist_pkg.sv
// Shared definitions for the BIST engines: FSM state encoding, the 16-bit
// polynomial tap mask, and the LFSR/MISR next-state helpers.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // Taps b14/b13/b11 of the left-shifted word, equivalent to feedback
    // b15^b13^b12^b10 of the unshifted word (x^16+x^14+x^13+x^11+1).
    localparam logic [15:0] POLY16 = 16'h6800;

    // One Fibonacci step: shift left, feedback enters at b0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] sig);
        logic fb;
        fb = sig[15] ^ (^({sig[14:0], 1'b0} & POLY16));
        return {sig[14:0], fb};
    endfunction

    // MISR step: same shift as the LFSR with the response folded in.
    function automatic logic [15:0] misr16_next(input logic [15:0] sig,
                                                input logic [15:0] resp);
        return lfsr16_next(sig) ^ resp;
    endfunction

endpackage

// File: rtl/bist_misr16.sv
// 16-bit multiple-input signature register with synchronous clear and
// absorb enable; clear has priority over enable.
module bist_misr16
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [15:0] i_data,
    output logic [15:0] o_sig
);

    logic [15:0] r_sig;

    // Signature register: clear at run start, fold one response when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= 16'h0000;
        end else if (i_clear) begin
            r_sig <= 16'h0000;
        end else if (i_enable) begin
            r_sig <= misr16_next(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/c17_bist_engine.sv
// BIST engine for small combinational CUTs (c17 by default): launches one
// pattern per cycle, captures each response one edge after its pattern,
// folds it into a MISR on the following edge (FLUSH drains the last one),
// and compares the final signature with GOLDEN_SIG.
// Build option BIST_EXHAUSTIVE_EN: pattern source becomes a binary up-counter
// and the run length becomes 2**PI_W; the LFSR is not built.
module c17_bist_engine
    import bist_pkg::*;
#(
    parameter int          PI_W       = 5,
    parameter int          PO_W       = 2,
    parameter int          N_PATTERNS = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PI_W-1:0] pattern,
    input  logic [PO_W-1:0] response,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature
);

`ifdef BIST_EXHAUSTIVE_EN
    localparam int N_EFF = 1 << PI_W;
`else
    localparam int N_EFF = N_PATTERNS;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
`endif
    localparam logic [15:0] LAST_IDX = 16'(N_EFF - 1);

    bist_state_t     r_state;
    bist_state_t     w_next_state;
    logic            w_accept;
    logic            w_last;
    logic            w_advance;
    logic            w_misr_en;
    logic [15:0]     r_cnt;
    logic [PI_W-1:0] r_pattern;
    logic [PI_W-1:0] w_first_pattern;
    logic [PI_W-1:0] w_next_pattern;
    logic [PO_W-1:0] r_resp;
    logic            r_pass;
    logic [15:0]     w_sig;

    assign w_last    = (r_cnt == LAST_IDX);
    assign w_advance = (r_state == RUN) && !w_last;
    // The first RUN edge has no captured response yet; from then on every
    // RUN edge and the FLUSH edge fold exactly one response.
    assign w_misr_en = ((r_state == RUN) && (r_cnt != 16'h0000)) || (r_state == FLUSH);

`ifdef BIST_EXHAUSTIVE_EN
    assign w_first_pattern = '0;
    assign w_next_pattern  = r_pattern + PI_W'(1);
`else
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    assign w_lfsr_next     = lfsr16_next(r_lfsr);
    assign w_first_pattern = SEED_EFF[PI_W-1:0];
    assign w_next_pattern  = w_lfsr_next[PI_W-1:0];

    // LFSR holds the state behind the pattern currently on the CUT inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_EFF;
        end else if (w_accept) begin
            r_lfsr <= SEED_EFF;
        end else if (w_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status decode; start is honoured only from IDLE or DONE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                busy         = 1'b1;
                w_next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pattern launch, pattern counter, response capture and pass verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pattern <= '0;
            r_cnt     <= 16'h0000;
            r_resp    <= '0;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_pattern <= w_first_pattern;
            r_cnt     <= 16'h0000;
            r_resp    <= '0;
            r_pass    <= 1'b0;
        end else if (r_state == RUN) begin
            r_resp <= response;
            if (!w_last) begin
                r_pattern <= w_next_pattern;
                r_cnt     <= r_cnt + 16'h0001;
            end
        end else if (r_state == FLUSH) begin
            r_pass <= (misr16_next(w_sig, 16'(r_resp)) == GOLDEN_SIG);
        end
    end

    bist_misr16 u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept),
        .i_enable (w_misr_en),
        .i_data   (16'(r_resp)),
        .o_sig    (w_sig)
    );

    assign pattern   = r_pattern;
    assign pass      = r_pass;
    assign signature = w_sig;

endmodule
